// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - RV32I branch resolve, 2-bit BHT predictor, mispredict pulse
// Optional statistics counters enabled by defining BRANCH_STATS_EN.
module branch_predict_unit #(
  parameter int         PC_W      = 32,
  parameter int         BHT_DEPTH = 16,
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            res_valid,
  input  logic [PC_W-1:0] res_pc,
  input  logic [2:0]      branch_op,
  input  logic            zf,
  input  logic            negative,
  input  logic            carry,
  input  logic            pred_was_taken,
  output logic            branch_sel,
  output logic            mispredict,
  output logic            redirect_taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       r_bht [BHT_DEPTH];
  logic             r_mispredict;
  logic             r_redirect_taken;
  logic [IDX_W-1:0] w_pred_idx;
  logic [IDX_W-1:0] w_res_idx;
  logic             w_legal;
  logic             w_cond;
  logic             w_update;
  logic             w_mis_next;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_next;
  logic             w_unused_pc;

  assign w_pred_idx  = pred_pc[IDX_W+1:2];
  assign w_res_idx   = res_pc[IDX_W+1:2];
  assign w_unused_pc = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                         res_pc[PC_W-1:IDX_W+2], res_pc[1:0]};

  always_comb begin
    w_legal = 1'b1;
    w_cond  = 1'b0;
    case (branch_op)
      3'b000:  w_cond = zf;
      3'b001:  w_cond = ~zf;
      3'b100:  w_cond = negative;
      3'b101:  w_cond = ~negative;
      3'b110:  w_cond = carry;
      3'b111:  w_cond = ~carry;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_update   = res_valid & w_legal;
  assign branch_sel = w_update & w_cond;
  assign w_mis_next = w_update & (branch_sel != pred_was_taken);

  // Lookup reads the registered table only; same-index writes show up a cycle later.
  assign pred_taken = r_bht[w_pred_idx][1];
  assign w_ctr_cur  = r_bht[w_res_idx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (w_cond && w_ctr_cur != 2'b11)
      w_ctr_next = w_ctr_cur + 2'b01;
    else if (!w_cond && w_ctr_cur != 2'b00)
      w_ctr_next = w_ctr_cur - 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        r_bht[i] <= CTR_INIT;
      r_mispredict     <= 1'b0;
      r_redirect_taken <= 1'b0;
    end else begin
      if (w_update)
        r_bht[w_res_idx] <= w_ctr_next;
      r_mispredict <= w_mis_next;
      if (w_mis_next)
        r_redirect_taken <= branch_sel;
    end
  end

  assign mispredict     = r_mispredict;
  assign redirect_taken = r_redirect_taken;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispred;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_branches <= 32'd0;
      r_stat_mispred  <= 32'd0;
    end else begin
      if (w_update && r_stat_branches != 32'hFFFF_FFFF)
        r_stat_branches <= r_stat_branches + 32'd1;
      if (w_mis_next && r_stat_mispred != 32'hFFFF_FFFF)
        r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_mispred  = r_stat_mispred;
`endif

endmodule
